conf_int_mac_acc__arch_agnos: RTL and testbench



---
 rtl/conf_int_mac_acc__arch_agnos.sv | 127 ++++++++++++
 tb/tb_conf_int_mac_acc__arch_agnos.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_mac_acc__arch_agnos.sv
// conf_int_mac_acc__arch_agnos
// Accumulate half of an integer MAC pipeline. Sums an unsigned product stream
// over a group ended by in_last, then holds the sum, a rounded/scaled result,
// the beat count and an overflow flag until the downstream takes them.
// Optional feature macro CONF_INT_MAC_ACC_SAT_EN: saturate the accumulator and
// the scaled result instead of wrapping/truncating.
module conf_int_mac_acc__arch_agnos #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_GUARD_BITS     = 8,
  parameter int OUT_SHIFT          = 16,
  parameter int CNT_BITWIDTH       = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [2*DATA_PATH_BITWIDTH-1:0]                in_prod,
  input  logic                                           in_valid,
  input  logic                                           in_last,
  output logic                                           in_ready,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [2*DATA_PATH_BITWIDTH+ACC_GUARD_BITS-1:0] out_sum,
  output logic [OP_BITWIDTH-1:0]                         out_scaled,
  output logic [CNT_BITWIDTH-1:0]                        out_cnt,
  output logic                                           out_ovf
);

  localparam int ACC_BITWIDTH = 2*DATA_PATH_BITWIDTH + ACC_GUARD_BITS;
  localparam int SUM_W        = ACC_BITWIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;

  state_t                  state_q, state_d;
  logic [ACC_BITWIDTH-1:0] acc_q, acc_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    accept;
  logic [SUM_W-1:0]        sum_wide;

  // Fold the carry of a wide sum back into the accumulator width.
  function automatic logic [ACC_BITWIDTH-1:0] acc_update(input logic [SUM_W-1:0] s);
`ifdef CONF_INT_MAC_ACC_SAT_EN
    if (s[ACC_BITWIDTH]) return '1;
`endif
    return ACC_BITWIDTH'(s);
  endfunction

  // Round half up, shift right, then truncate or clamp to the result width.
  function automatic logic [OP_BITWIDTH-1:0] scale_round(input logic [ACC_BITWIDTH-1:0] a);
    logic [SUM_W-1:0] rnd;
    logic [SUM_W-1:0] r;
    rnd = '0;
    if (OUT_SHIFT > 0) rnd[OUT_SHIFT-1] = 1'b1;
    r = (SUM_W'(a) + rnd) >> OUT_SHIFT;
`ifdef CONF_INT_MAC_ACC_SAT_EN
    if ((r >> OP_BITWIDTH) != '0) return '1;
`endif
    return OP_BITWIDTH'(r);
  endfunction

  assign accept   = in_valid && in_ready;
  assign sum_wide = SUM_W'(acc_q) + SUM_W'(in_prod);

  // Next-state for the group FSM, accumulator, beat counter and overflow flag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = ACC_BITWIDTH'(in_prod);
          cnt_d   = CNT_BITWIDTH'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d   = acc_update(sum_wide);
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITWIDTH'(1);
          ovf_d   = ovf_q | sum_wide[ACC_BITWIDTH];
          state_d = in_last ? ST_OUT : ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register all state; reset discards any partial group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from the registers (scaled result via pure logic).
  assign in_ready   = (state_q != ST_OUT);
  assign out_valid  = (state_q == ST_OUT);
  assign out_sum    = acc_q;
  assign out_cnt    = cnt_q;
  assign out_ovf    = ovf_q;
  assign out_scaled = scale_round(acc_q);

endmodule

// File: tb/tb_conf_int_mac_acc__arch_agnos.sv
// Testbench for conf_int_mac_acc__arch_agnos: table of directed groups,
// hand-written reset/backpressure sequences, and randomized groups checked
// against a group-level arithmetic model.
module tb_conf_int_mac_acc__arch_agnos;

  localparam int OPW = 16;
  localparam int DPW = 16;
  localparam int GB  = 8;
  localparam int SH  = 16;
  localparam int CW  = 16;
  localparam int AW  = 2*DPW + GB;

`ifdef CONF_INT_MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [2*DPW-1:0] in_prod;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sum;
  logic [OPW-1:0]  out_scaled;
  logic [CW-1:0]   out_cnt;
  logic            out_ovf;

  conf_int_mac_acc__arch_agnos #(
    .OP_BITWIDTH(OPW), .DATA_PATH_BITWIDTH(DPW), .ACC_GUARD_BITS(GB),
    .OUT_SHIFT(SH), .CNT_BITWIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_scaled(out_scaled),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] sum;
    logic [15:0] scaled;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] prod;
    int unsigned n;
    bit          gap;
    res_t        exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Group-level model: the sum of all beats in plain wide arithmetic.
  function automatic res_t model(input logic [63:0] total, input int unsigned n);
    res_t r;
    logic [63:0] amax;
    logic [63:0] rr;
    logic [63:0] half;
    amax  = (64'd1 << AW) - 64'd1;
    half  = (SH > 0) ? (64'd1 << (SH - 1)) : 64'd0;
    r.ovf = (total > amax);
    if (SAT && r.ovf) r.sum = amax[39:0];
    else              r.sum = total[39:0];
    rr = ({24'd0, r.sum} + half) >> SH;
    if (SAT && rr > 64'hFFFF) r.scaled = 16'hFFFF;
    else                      r.scaled = rr[15:0];
    r.cnt = (n > 32'd65535) ? 16'hFFFF : n[15:0];
    return r;
  endfunction

  // Present one beat and wait (bounded) until it is taken.
  task automatic drive_beat(input logic [31:0] p, input logic last);
    int guard;
    guard    = 0;
    in_prod  = p;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_group(input logic [31:0] p, input int unsigned n, input bit gap);
    for (int unsigned k = 0; k < n; k++) begin
      drive_beat(p, k == n - 1);
      if (gap && k < n - 1) tick();
    end
  endtask

  // Called while the result is being presented; releases it and checks IDLE.
  task automatic check_result(input string tag, input res_t e);
    check({tag, "_valid"},  out_valid,  1);
    check({tag, "_ready"},  in_ready,   0);
    check({tag, "_sum"},    out_sum,    e.sum);
    check({tag, "_scaled"}, out_scaled, e.scaled);
    check({tag, "_cnt"},    out_cnt,    e.cnt);
    check({tag, "_ovf"},    out_ovf,    e.ovf);
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready,  1);
    check({tag, "_idle_sum"},   out_sum,   0);
    check({tag, "_idle_cnt"},   out_cnt,   0);
  endtask

  vec_t vt[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        e;
    logic [63:0] total;
    logic [31:0] p;
    int unsigned n;
    int unsigned stall;
    logic [39:0] held;

    vt[0] = '{32'h00010000, 1,   1'b0, '{40'h0000010000, 16'h0001, 16'd1, 1'b0}};
    vt[1] = '{32'hFFFE0001, 3,   1'b0, '{40'h02FFFA0003, SAT ? 16'hFFFF : 16'hFFFA, 16'd3, 1'b0}};
    vt[2] = '{32'h00000003, 4,   1'b1, '{40'h000000000C, 16'h0000, 16'd4, 1'b0}};
    vt[3] = '{32'hFFFE0001, 257, 1'b0, '{SAT ? 40'hFFFFFFFFFF : 40'h00FDFE0101,
                                         SAT ? 16'hFFFF : 16'hFDFE, 16'd257, 1'b1}};
    vt[4] = '{32'hFFFFFFFF, 1,   1'b0, '{40'h00FFFFFFFF, SAT ? 16'hFFFF : 16'h0000, 16'd1, 1'b0}};
    vt[5] = '{32'h00008000, 1,   1'b0, '{40'h0000008000, 16'h0001, 16'd1, 1'b0}};
    vt[6] = '{32'h00007FFF, 1,   1'b0, '{40'h0000007FFF, 16'h0000, 16'd1, 1'b0}};

    rst       = 1'b0;
    in_prod   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",  out_valid,  0);
    check("rst_sum",    out_sum,    0);
    check("rst_cnt",    out_cnt,    0);
    check("rst_ovf",    out_ovf,    0);
    check("rst_scaled", out_scaled, 0);
    rst = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);

    // Reset in the middle of a group discards it.
    drive_beat(32'h00001111, 1'b0);
    drive_beat(32'h00002222, 1'b0);
    check("mid_cnt", out_cnt, 2);
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_sum",   out_sum,   0);
    check("midrst_cnt",   out_cnt,   0);
    check("midrst_ready", in_ready,  1);
    run_group(32'h5, 1, 1'b0);
    check_result("fresh", '{40'h5, 16'h0, 16'd1, 1'b0});

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_group(vt[i].prod, vt[i].n, vt[i].gap);
      check_result($sformatf("vec%0d", i), vt[i].exp);
    end

    // Backpressure: result held, beats refused while presenting.
    out_ready = 1'b0;
    run_group(32'h12345678, 1, 1'b0);
    in_prod  = 32'h0000AAAA;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp%0d_valid", s), out_valid, 1);
      check($sformatf("bp%0d_ready", s), in_ready,  0);
      check($sformatf("bp%0d_sum", s),   out_sum,   40'h12345678);
      check($sformatf("bp%0d_cnt", s),   out_cnt,   1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_ready", in_ready,  1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_sum",   out_sum,   40'hAAAA);
    check("bp_next_cnt",   out_cnt,   1);
    tick();
    check("bp_next_idle", out_valid, 0);

    // Randomized groups against the arithmetic model.
    for (int g = 0; g < 40; g++) begin
      n     = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 12);
      stall = $urandom_range(0, 3);
      total = '0;
      out_ready = (stall == 0);
      for (int unsigned k = 0; k < n; k++) begin
        p = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        total += {32'd0, p};
        drive_beat(p, k == n - 1);
        if (k < n - 1 && $urandom_range(0, 2) == 0) tick();
      end
      e    = model(total, n);
      held = out_sum;
      for (int unsigned s = 0; s < stall; s++) begin
        in_prod  = $urandom;
        in_valid = 1'b1;
        check($sformatf("rnd%0d_stall_valid", g), out_valid, 1);
        check($sformatf("rnd%0d_stall_ready", g), in_ready,  0);
        tick();
        check($sformatf("rnd%0d_stall_sum", g), out_sum, held);
      end
      in_valid = 1'b0;
      check_result($sformatf("rnd%0d", g), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
